// File: rtl/core_mau_pl_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_mau_pl_if
//  Description : Request/response and pipelined wishbone signal bundle for
//                the pipelined load/store unit.
//                master : load/store unit view. It takes requests from the
//                         execute stage, returns responses and drives the
//                         data bus.
//                slave  : environment view. It is the execute stage plus
//                         the wishbone slave.
//  Ports       : req_*  request from execute (valid/ready handshake)
//                rsp_*  in-order response pulse, busy status
//                bus_*  pipelined wishbone data bus
//  Revision    : 1.0  initial release
// ============================================================================
interface core_mau_pl_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;

    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              busy;

    logic              bus_cyc;
    logic              bus_stb;
    logic              bus_we;
    logic [AW-1:0]     bus_adr;
    logic [DW/8-1:0]   bus_sel;
    logic [DW-1:0]     bus_dat_mo;
    logic [DW-1:0]     bus_dat_so;
    logic              bus_ack;
    logic              bus_err;
    logic              bus_stall;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err, busy,
        output bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_mo,
        input  bus_dat_so, bus_ack, bus_err, bus_stall
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err, busy,
        input  bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_mo,
        output bus_dat_so, bus_ack, bus_err, bus_stall
    );
endinterface
`default_nettype wire

// File: rtl/core_mau_pl.sv
`default_nettype none
// ============================================================================
//  Module      : core_mau_pl
//  Description : Pipelined load/store unit. It issues LD/ST requests on a
//                pipelined wishbone bus with up to DEPTH accesses in flight.
//                Responses return in request order. Each response carries
//                lane-aligned, sign- or zero-extended load data and an error
//                flag for a misaligned access or a bus error.
//  Ports       : clk  clock, posedge
//                rst  asynchronous active-high reset
//                mau  core_mau_pl_if.master (request, response, wishbone)
//  Revision    : 1.0  initial release
// ============================================================================
module core_mau_pl #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    core_mau_pl_if.master   mau
);
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = 4 + LW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [TW-1:0]     r_tag [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              r_we;
    logic [AW-1:0]     r_adr;
    logic [NB-1:0]     r_sel;
    logic [DW-1:0]     r_dat;

    logic              r_rsp_valid;
    logic [DW-1:0]     r_rsp_data;
    logic              r_rsp_err;
    logic              r_mis_pend;

    logic [LW-1:0]     w_lo;
    logic              w_mis;
    logic              w_stb;
    logic              w_empty;
    logic              w_full;
    logic              w_ready;
    logic              w_acc;
    logic              w_push;
    logic              w_acc_mis;
    logic              w_pop;
    logic              w_last_pop;
    logic [NB-1:0]     w_sel;
    logic [DW-1:0]     w_dat;

    logic [TW-1:0]     w_head;
    logic              w_h_we;
    logic [1:0]        w_h_size;
    logic              w_h_sgn;
    logic [LW-1:0]     w_h_lo;
    logic [DW-1:0]     w_shifted;
    logic [DW-1:0]     w_ld;
    logic              w_fill;
    int                w_nbits;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_lo = mau.req_addr[LW-1:0];

    always_comb begin
        w_mis = 1'b0;
        case (mau.req_size)
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = w_lo[0];
            2'd2:    w_mis = |w_lo[1:0];
            default: w_mis = |w_lo;
        endcase
    end

    // stb is asserted exactly while the FSM is in ISSUE
    assign w_stb   = (r_state == S_ISSUE);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A misaligned request never touches the bus. It is only taken when
    // nothing is in flight, so its response cannot overtake a bus response.
    assign w_ready   = (!w_stb || !mau.bus_stall) && !w_full
                       && (!w_mis || (w_empty && !w_stb));
    assign w_acc     = mau.req_valid && w_ready;
    assign w_push    = w_acc && !w_mis;
    assign w_acc_mis = w_acc && w_mis;

    // ack or err with an empty tag FIFO is ignored
    assign w_pop      = (mau.bus_ack || mau.bus_err) && !w_empty;
    assign w_last_pop = w_pop && !w_push && (r_count == CW'(1));

    // ------------------------------------------------------------------
    // Lane select and write-data replication
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = '0;
        case (mau.req_size)
            2'd0:    w_sel = NB'(1);
            2'd1:    w_sel = NB'(3);
            2'd2:    w_sel = NB'(4'hF);
            default: w_sel = '1;
        endcase
        w_sel = w_sel << w_lo;
    end

    always_comb begin
        w_dat = '0;
        case (mau.req_size)
            2'd0:    w_dat = {NB{mau.req_wdata[7:0]}};
            2'd1:    w_dat = {(NB/2){mau.req_wdata[15:0]}};
            2'd2:    w_dat = {(NB/4){mau.req_wdata[31:0]}};
            default: w_dat = mau.req_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus cycle FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_state_nxt
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The slave may complete the final access in the same
                // cycle it takes stb. In that case go straight to IDLE.
                if (!mau.bus_stall && !w_push) begin
                    w_state_nxt = w_last_pop ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_push) begin
                    w_state_nxt = S_ISSUE;
                end else if (w_last_pop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe payload registers
    // These load on every accept, including the cycle the previous strobe
    // is taken, and hold while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_bus
        if (rst) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_sel <= '0;
            r_dat <= '0;
        end else if (w_push) begin
            r_we  <= mau.req_we;
            r_adr <= {mau.req_addr[AW-1:LW], {LW{1'b0}}};
            r_sel <= w_sel;
            r_dat <= w_dat;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO: {we, size, signed, lo} per outstanding access
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_fifo
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= {mau.req_we, mau.req_size, mau.req_signed, w_lo};
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension for the FIFO head
    // ------------------------------------------------------------------
    assign w_head   = r_tag[r_rptr];
    assign w_h_we   = w_head[TW-1];
    assign w_h_size = w_head[TW-2:TW-3];
    assign w_h_sgn  = w_head[TW-4];
    assign w_h_lo   = w_head[LW-1:0];

    assign w_shifted = mau.bus_dat_so >> {w_h_lo, 3'b000};

    always_comb begin
        w_nbits = 8 << w_h_size;
        w_fill  = 1'b0;
        case (w_h_size)
            2'd0:    w_fill = w_h_sgn & w_shifted[7];
            2'd1:    w_fill = w_h_sgn & w_shifted[15];
            2'd2:    w_fill = w_h_sgn & w_shifted[31];
            default: w_fill = 1'b0;
        endcase
        w_ld = w_shifted;
        for (int i = 0; i < DW; i++) begin
            if (i >= w_nbits) begin
                w_ld[i] = w_fill;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_rsp
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mis_pend  <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop || w_acc_mis;
            r_rsp_err   <= w_pop ? mau.bus_err : w_acc_mis;
            r_rsp_data  <= (w_pop && !w_h_we) ? w_ld : '0;
            r_mis_pend  <= w_acc_mis;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mau.req_ready  = w_ready;
    assign mau.rsp_valid  = r_rsp_valid;
    assign mau.rsp_data   = r_rsp_data;
    assign mau.rsp_err    = r_rsp_err;
    assign mau.busy       = w_stb || !w_empty || r_mis_pend;
    assign mau.bus_cyc    = (r_state != S_IDLE);
    assign mau.bus_stb    = w_stb;
    assign mau.bus_we     = r_we;
    assign mau.bus_adr    = r_adr;
    assign mau.bus_sel    = r_sel;
    assign mau.bus_dat_mo = r_dat;
endmodule
`default_nettype wire

// File: tb/tb_core_mau_pl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mau_pl
//  Description : Self-checking bench for core_mau_pl (DW=32, DEPTH=4).
//                Directed scenarios cover reset, single loads and stores,
//                misalignment, back-to-back issue with stalls, bus error
//                and reset while accesses are in flight. A randomized run
//                with a random-latency slave is checked against a reference
//                model of the load/store rules.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_mau_pl;
    localparam int NRAND = 150;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    core_mau_pl_if #(.DW(32), .AW(32)) ifc ();

    core_mau_pl #(.DW(32), .AW(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .mau (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'b0;
        ifc.req_size   = 2'd0;
        ifc.req_signed = 1'b0;
        ifc.req_addr   = '0;
        ifc.req_wdata  = '0;
        ifc.bus_dat_so = '0;
        ifc.bus_ack    = 1'b0;
        ifc.bus_err    = 1'b0;
        ifc.bus_stall  = 1'b0;
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic errfn(input logic [31:0] a);
        logic [31:0] h;
        h = hash(a);
        return h[7:4] == 4'hF;
    endfunction

    // Reference: the response a request should produce when the slave
    // returns hash(word address) and flags errfn(word address).
    function automatic void model(input logic we, input logic [1:0] size,
                                  input logic sgn, input logic [31:0] addr,
                                  output logic [31:0] data, output logic err);
        int          nb;
        logic [31:0] v;
        logic [31:0] m;
        nb = 8 << size;
        if ((addr % (32'd1 << size)) != 0) begin
            data = 32'd0;
            err  = 1'b1;
            return;
        end
        err = errfn({addr[31:2], 2'b00});
        if (we) begin
            data = 32'd0;
            return;
        end
        v = hash({addr[31:2], 2'b00}) >> (8 * addr[1:0]);
        if (nb < 32) begin
            m = (32'd1 << nb) - 32'd1;
            v = v & m;
            if (sgn && v[nb-1]) v = v | ~m;
        end
        data = v;
    endfunction

    // Drives a single request. If it is issued, the task acks it one
    // cycle after the strobe and returns what was observed on the bus and
    // on the response.
    task automatic single_access(input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] dat,
                                 input logic err,
                                 output logic stb_seen, output logic [3:0] sel,
                                 output logic [31:0] adr, output logic [31:0] dmo,
                                 output logic rv, output logic [31:0] rd,
                                 output logic re, output logic cyc_after);
        tick();
        ifc.req_valid  = 1'b1;
        ifc.req_we     = we;
        ifc.req_size   = size;
        ifc.req_signed = sgn;
        ifc.req_addr   = addr;
        ifc.req_wdata  = wdata;
        tick();
        ifc.req_valid = 1'b0;
        @(negedge clk);
        stb_seen  = ifc.bus_stb;
        sel       = ifc.bus_sel;
        adr       = ifc.bus_adr;
        dmo       = ifc.bus_dat_mo;
        rv        = ifc.rsp_valid;
        rd        = ifc.rsp_data;
        re        = ifc.rsp_err;
        cyc_after = ifc.bus_cyc;
        if (stb_seen) begin
            tick();
            ifc.bus_ack    = !err;
            ifc.bus_err    = err;
            ifc.bus_dat_so = dat;
            tick();
            ifc.bus_ack = 1'b0;
            ifc.bus_err = 1'b0;
            @(negedge clk);
            rv        = ifc.rsp_valid;
            rd        = ifc.rsp_data;
            re        = ifc.rsp_err;
            cyc_after = ifc.bus_cyc;
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_err, ifc.busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_status: got ready/rv/err/busy=%b want 1000",
                     {ifc.req_ready, ifc.rsp_valid, ifc.rsp_err, ifc.busy});
        end
        n_cmp++;
        if ({ifc.bus_cyc, ifc.bus_stb, ifc.bus_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_bus_ctl: got cyc/stb/we=%b want 000",
                     {ifc.bus_cyc, ifc.bus_stb, ifc.bus_we});
        end
        n_cmp++;
        if ({ifc.bus_adr, ifc.bus_sel, ifc.bus_dat_mo, ifc.rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got adr=%h sel=%h dat_mo=%h rsp_data=%h want all 0",
                     ifc.bus_adr, ifc.bus_sel, ifc.bus_dat_mo, ifc.rsp_data);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        logic stb; logic [3:0] sel; logic [31:0] adr, dmo, rd; logic rv, re, cyc;
        single_access(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 32'h8000_0001, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({stb, sel, adr} !== {1'b1, 4'hF, 32'h100}) begin
            n_fail++;
            $display("FAIL ldw_bus: got stb=%b sel=%h adr=%h want 1 f 00000100", stb, sel, adr);
        end
        n_cmp++;
        if ({rv, re, rd} !== {1'b1, 1'b0, 32'h8000_0001}) begin
            n_fail++;
            $display("FAIL ldw_rsp: got v=%b err=%b data=%h want 1 0 80000001", rv, re, rd);
        end
        n_cmp++;
        if (cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL ldw_cyc_drop: got cyc=%b want 0", cyc);
        end
    endtask

    task automatic test_byte_load();
        logic stb; logic [3:0] sel; logic [31:0] adr, dmo, rd; logic rv, re, cyc;
        single_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({sel, adr} !== {4'h8, 32'h100}) begin
            n_fail++;
            $display("FAIL ldb_bus: got sel=%h adr=%h want 8 00000100", sel, adr);
        end
        n_cmp++;
        if ({rv, rd} !== {1'b1, 32'hFFFF_FF80}) begin
            n_fail++;
            $display("FAIL ldb_signed: got v=%b data=%h want 1 ffffff80", rv, rd);
        end
        single_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({rv, rd} !== {1'b1, 32'h0000_0080}) begin
            n_fail++;
            $display("FAIL ldb_unsigned: got v=%b data=%h want 1 00000080", rv, rd);
        end
        single_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8ABC_1234, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({sel, rd} !== {4'hC, 32'hFFFF_8ABC}) begin
            n_fail++;
            $display("FAIL ldh_signed: got sel=%h data=%h want c ffff8abc", sel, rd);
        end
    endtask

    task automatic test_store();
        logic stb; logic [3:0] sel; logic [31:0] adr, dmo, rd; logic rv, re, cyc;
        single_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({sel, adr, dmo} !== {4'hC, 32'h200, 32'h1234_1234}) begin
            n_fail++;
            $display("FAIL sth_bus: got sel=%h adr=%h dat_mo=%h want c 00000200 12341234",
                     sel, adr, dmo);
        end
        n_cmp++;
        if ({rv, re, rd} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL sth_rsp: got v=%b err=%b data=%h want 1 0 00000000", rv, re, rd);
        end
        single_access(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00A5, 32'h0, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({sel, dmo} !== {4'h2, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL stb_bus: got sel=%h dat_mo=%h want 2 a5a5a5a5", sel, dmo);
        end
    endtask

    task automatic test_misaligned();
        logic stb; logic [3:0] sel; logic [31:0] adr, dmo, rd; logic rv, re, cyc;
        single_access(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0,
                      stb, sel, adr, dmo, rv, rd, re, cyc);
        n_cmp++;
        if ({stb, cyc} !== 2'b00) begin
            n_fail++;
            $display("FAIL mis_no_bus: got stb=%b cyc=%b want 0 0", stb, cyc);
        end
        n_cmp++;
        if ({rv, re, rd} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL mis_rsp: got v=%b err=%b data=%h want 1 1 00000000", rv, re, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_d[$];
        logic        got_e[$];
        int          idx;
        for (int c = 0; c < 12; c++) begin
            tick();
            idx = (c <= 1) ? c : (c <= 4) ? 2 : 3;
            ifc.req_valid  = (c <= 5);
            ifc.req_we     = 1'b0;
            ifc.req_size   = 2'd2;
            ifc.req_signed = 1'b0;
            ifc.req_addr   = 32'h300 + 32'(4 * idx);
            ifc.bus_stall  = (c == 2 || c == 3);
            ifc.bus_ack    = (c >= 7 && c <= 10);
            ifc.bus_dat_so = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            if (c == 2 || c == 3) begin
                n_cmp++;
                if ({ifc.bus_stb, ifc.bus_adr, ifc.req_ready} !== {1'b1, 32'h304, 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_stall_c%0d: got stb=%b adr=%h ready=%b want 1 00000304 0",
                             c, ifc.bus_stb, ifc.bus_adr, ifc.req_ready);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (ifc.req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full_ready: got %b want 0", ifc.req_ready);
                end
            end
            if (c == 10) begin
                n_cmp++;
                if (ifc.bus_cyc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_cyc_held: got %b want 1", ifc.bus_cyc);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if ({ifc.bus_cyc, ifc.busy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL b2b_cyc_drop: got cyc/busy=%b want 00", {ifc.bus_cyc, ifc.busy});
                end
            end
            if (ifc.rsp_valid) begin
                got_d.push_back(ifc.rsp_data);
                got_e.push_back(ifc.rsp_err);
            end
        end
        ifc.bus_ack = 1'b0;
        n_cmp++;
        if (got_d.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_rsp_count: got %0d want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({got_e[i], got_d[i]} !== {1'b0, 32'hA000_0007 + 32'(i)}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: got err=%b data=%h want 0 %h",
                             i, got_e[i], got_d[i], 32'hA000_0007 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_bus_err();
        logic [31:0] got_d[$];
        logic        got_e[$];
        for (int c = 0; c < 9; c++) begin
            tick();
            ifc.req_valid  = (c <= 2);
            ifc.req_we     = 1'b0;
            ifc.req_size   = 2'd2;
            ifc.req_signed = 1'b0;
            ifc.req_addr   = 32'h400 + 32'(4 * c);
            ifc.bus_stall  = 1'b0;
            ifc.bus_ack    = (c == 4 || c == 6);
            ifc.bus_err    = (c == 5);
            ifc.bus_dat_so = 32'hB000_0000 + 32'(c);
            @(negedge clk);
            if (c == 6) begin
                n_cmp++;
                if (ifc.bus_cyc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_no_abort: got cyc=%b want 1", ifc.bus_cyc);
                end
            end
            if (ifc.rsp_valid) begin
                got_d.push_back(ifc.rsp_data);
                got_e.push_back(ifc.rsp_err);
            end
        end
        ifc.bus_ack = 1'b0;
        ifc.bus_err = 1'b0;
        n_cmp++;
        if (got_d.size() != 3) begin
            n_fail++;
            $display("FAIL err_rsp_count: got %0d want 3", got_d.size());
        end else begin
            n_cmp++;
            if ({got_e[0], got_e[1], got_e[2]} !== 3'b010) begin
                n_fail++;
                $display("FAIL err_flags: got %b want 010", {got_e[0], got_e[1], got_e[2]});
            end
            n_cmp++;
            if ({got_d[0], got_d[2]} !== {32'hB000_0004, 32'hB000_0006}) begin
                n_fail++;
                $display("FAIL err_ok_data: got %h %h want b0000004 b0000006", got_d[0], got_d[2]);
            end
        end
    endtask

    task automatic test_reset_midburst();
        int extra;
        for (int c = 0; c < 3; c++) begin
            tick();
            ifc.req_valid  = (c <= 1);
            ifc.req_we     = 1'b0;
            ifc.req_size   = 2'd2;
            ifc.req_addr   = 32'h500 + 32'(4 * c);
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ifc.bus_cyc, ifc.bus_stb, ifc.busy, ifc.rsp_valid, ifc.req_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL rstmid_ctl: got cyc/stb/busy/rv/ready=%b want 00001",
                     {ifc.bus_cyc, ifc.bus_stb, ifc.busy, ifc.rsp_valid, ifc.req_ready});
        end
        n_cmp++;
        if ({ifc.bus_adr, ifc.bus_sel, ifc.bus_we} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_bus: got adr=%h sel=%h we=%b want 0",
                     ifc.bus_adr, ifc.bus_sel, ifc.bus_we);
        end
        tick();
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            ifc.bus_ack = (c < 3);
            @(negedge clk);
            if (ifc.rsp_valid) extra++;
        end
        ifc.bus_ack = 1'b0;
        n_cmp++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL rstmid_stale_rsp: got %0d responses want 0", extra);
        end
    endtask

    task automatic test_random();
        exp_t        exq[$];
        pend_t       pend[$];
        exp_t        e;
        pend_t       p;
        int          sent, got, cyc;
        logic        acc_last;
        logic        be;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        acc_last = 1'b1;
        while (got < NRAND && cyc < 5000) begin
            tick();
            cyc++;
            if (!ifc.req_valid || acc_last) begin
                if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                    ifc.req_valid  = 1'b1;
                    ifc.req_we     = 1'($urandom_range(0, 1));
                    ifc.req_size   = 2'($urandom_range(0, 2));
                    ifc.req_signed = 1'($urandom_range(0, 1));
                    ifc.req_addr   = 32'($urandom_range(0, 1023));
                    ifc.req_wdata  = $urandom;
                end else begin
                    ifc.req_valid = 1'b0;
                end
            end
            ifc.bus_stall = ($urandom_range(0, 3) == 0);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p              = pend.pop_front();
                be             = errfn(p.adr);
                ifc.bus_ack    = !be;
                ifc.bus_err    = be;
                ifc.bus_dat_so = hash(p.adr);
            end else begin
                ifc.bus_ack    = 1'b0;
                ifc.bus_err    = 1'b0;
                ifc.bus_dat_so = $urandom;
            end
            @(negedge clk);
            acc_last = ifc.req_valid && ifc.req_ready;
            if (acc_last) begin
                model(ifc.req_we, ifc.req_size, ifc.req_signed, ifc.req_addr, e.data, e.err);
                exq.push_back(e);
                sent++;
            end
            if (ifc.bus_stb && !ifc.bus_stall) begin
                p.adr = ifc.bus_adr;
                p.due = cyc + 1 + int'($urandom_range(0, 3));
                pend.push_back(p);
            end
            if (ifc.rsp_valid) begin
                n_cmp++;
                if (exq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected_rsp: got data=%h err=%b want none",
                             ifc.rsp_data, ifc.rsp_err);
                end else begin
                    e = exq.pop_front();
                    if ({ifc.rsp_err, ifc.rsp_data} !== {e.err, e.data}) begin
                        n_fail++;
                        $display("FAIL rand_rsp%0d: got err=%b data=%h want err=%b data=%h",
                                 got, ifc.rsp_err, ifc.rsp_data, e.err, e.data);
                    end
                end
                got++;
            end
        end
        idle_inputs();
        n_cmp++;
        if (got != NRAND) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d responses want %0d", got, NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_bus_err();
        test_random();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
